// File: rtl/soc_bus_xbar.sv
// rtl/soc_bus_xbar.sv - N-host x M-device request/grant crossbar with RR arbitration and in-order response routing
// Optional build macro SOC_BUS_XBAR_RSP_REG_EN registers the host response path (+1 cycle latency).
module soc_bus_xbar #(
  parameter int NumHosts       = 2,
  parameter int NumDevices     = 3,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int DevOutstanding = 2,
  parameter logic [NumDevices*AddrWidth-1:0] DevBase = {32'h0000_4000, 32'h0000_2000, 32'h0000_0000},
  parameter logic [NumDevices*AddrWidth-1:0] DevMask = {32'hFFFF_E000, 32'hFFFF_E000, 32'hFFFF_E000}
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumHosts-1:0]               host_req_i,
  input  logic [NumHosts-1:0]               host_we_i,
  input  logic [NumHosts*AddrWidth-1:0]     host_addr_i,
  input  logic [NumHosts*DataWidth-1:0]     host_wdata_i,
  input  logic [NumHosts*DataWidth/8-1:0]   host_be_i,
  output logic [NumHosts-1:0]               host_gnt_o,
  output logic [NumHosts-1:0]               host_rvalid_o,
  output logic [NumHosts*DataWidth-1:0]     host_rdata_o,
  output logic [NumHosts-1:0]               host_err_o,
  output logic [NumDevices-1:0]             dev_req_o,
  output logic [NumDevices-1:0]             dev_we_o,
  output logic [NumDevices*AddrWidth-1:0]   dev_addr_o,
  output logic [NumDevices*DataWidth-1:0]   dev_wdata_o,
  output logic [NumDevices*DataWidth/8-1:0] dev_be_o,
  input  logic [NumDevices-1:0]             dev_gnt_i,
  input  logic [NumDevices-1:0]             dev_rvalid_i,
  input  logic [NumDevices*DataWidth-1:0]   dev_rdata_i,
  input  logic [NumDevices-1:0]             dev_err_i
);

  localparam int BW = DataWidth / 8;
  localparam int HW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int TW = $clog2(NumDevices + 1);
  localparam int PW = (DevOutstanding > 1) ? $clog2(DevOutstanding) : 1;
  localparam int CW = $clog2(DevOutstanding + 1);
  localparam logic [TW-1:0] ErrTgt = TW'(NumDevices);

  logic [TW-1:0]         w_tgt [NumHosts];
  logic [NumHosts-1:0]   w_pend_eff;
  logic [NumHosts-1:0]   w_err_gnt;
  logic [NumHosts-1:0]   w_rsp_vld;
  logic [NumHosts-1:0]   w_rsp_err;
  logic [NumHosts*DataWidth-1:0] w_rsp_data;
  logic [NumDevices-1:0] w_win_vld;
  logic [HW-1:0]         w_win_id [NumDevices];
  logic [HW-1:0]         w_head [NumDevices];
  logic [NumDevices-1:0] w_push;
  logic [NumDevices-1:0] w_pop;
  logic [NumHosts-1:0]   r_pend;
  logic [NumHosts-1:0]   r_eresp;

  // First eligible host at or after ptr; returns {found, id}.
  function automatic logic [HW:0] rr_pick(input logic [NumHosts-1:0] elig, input logic [HW-1:0] ptr);
    logic [HW:0]         res;
    logic [NumHosts-1:0] sh;
    int                  idx;
    res = '0;
    for (int k = NumHosts - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NumHosts) idx = idx - NumHosts;
      sh = elig >> idx;
      if (sh[0]) res = {1'b1, HW'(idx)};
    end
    return res;
  endfunction

  // Lowest matching device wins; no match selects the internal error responder.
  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      w_tgt[h] = ErrTgt;
      for (int d = NumDevices - 1; d >= 0; d--) begin
        if ((host_addr_i[h*AddrWidth +: AddrWidth] & DevMask[d*AddrWidth +: AddrWidth])
            == DevBase[d*AddrWidth +: AddrWidth])
          w_tgt[h] = TW'(d);
      end
    end
  end

  assign w_pend_eff = r_pend & ~host_rvalid_o;

  always_comb begin
    for (int h = 0; h < NumHosts; h++)
      w_err_gnt[h] = host_req_i[h] & ~w_pend_eff[h] & (w_tgt[h] == ErrTgt) & ~rst_i;
  end

  always_comb begin
    host_gnt_o = w_err_gnt;
    for (int d = 0; d < NumDevices; d++)
      for (int h = 0; h < NumHosts; h++)
        if (w_push[d] && (w_win_id[d] == HW'(h))) host_gnt_o[h] = 1'b1;
  end

  // Each host has at most one response in flight, so sources never collide.
  always_comb begin
    w_rsp_vld  = r_eresp;
    w_rsp_err  = r_eresp;
    w_rsp_data = '0;
    for (int d = 0; d < NumDevices; d++)
      for (int h = 0; h < NumHosts; h++)
        if (w_pop[d] && (w_head[d] == HW'(h))) begin
          w_rsp_vld[h] = 1'b1;
          w_rsp_err[h] = w_rsp_err[h] | dev_err_i[d];
          w_rsp_data[h*DataWidth +: DataWidth] = w_rsp_data[h*DataWidth +: DataWidth]
                                                 | dev_rdata_i[d*DataWidth +: DataWidth];
        end
  end

`ifdef SOC_BUS_XBAR_RSP_REG_EN
  logic [NumHosts-1:0]           r_rvalid;
  logic [NumHosts-1:0]           r_err;
  logic [NumHosts*DataWidth-1:0] r_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rsp_vld;
      r_err    <= w_rsp_err;
      r_rdata  <= w_rsp_data;
    end
  end

  assign host_rvalid_o = r_rvalid;
  assign host_err_o    = r_err;
  assign host_rdata_o  = r_rdata;
`else
  assign host_rvalid_o = w_rsp_vld;
  assign host_err_o    = w_rsp_err;
  assign host_rdata_o  = w_rsp_data;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend  <= '0;
      r_eresp <= '0;
    end else begin
      r_pend  <= w_pend_eff | host_gnt_o;
      r_eresp <= w_err_gnt;
    end
  end

  for (genvar d = 0; d < NumDevices; d++) begin : g_dev
    logic [HW-1:0]       r_fifo [DevOutstanding];
    logic [PW-1:0]       r_wp;
    logic [PW-1:0]       r_rp;
    logic [CW-1:0]       r_cnt;
    logic [HW-1:0]       r_ptr;
    logic [NumHosts-1:0] w_elig;
    logic [HW:0]         w_pick;
    logic                w_we;
    logic [AddrWidth-1:0] w_addr;
    logic [DataWidth-1:0] w_wdata;
    logic [BW-1:0]        w_be;

    always_comb begin
      for (int h = 0; h < NumHosts; h++)
        w_elig[h] = host_req_i[h] & ~w_pend_eff[h] & (w_tgt[h] == TW'(d)) & ~rst_i;
    end

    assign w_pick       = rr_pick(w_elig, r_ptr);
    assign w_win_vld[d] = w_pick[HW];
    assign w_win_id[d]  = w_pick[HW-1:0];
    assign dev_req_o[d] = w_win_vld[d] & (r_cnt != CW'(DevOutstanding));
    assign w_push[d]    = dev_req_o[d] & dev_gnt_i[d];
    // A response with no recorded requester is dropped.
    assign w_pop[d]     = dev_rvalid_i[d] & (r_cnt != '0);
    assign w_head[d]    = r_fifo[r_rp];

    always_comb begin
      w_we    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      w_be    = '0;
      for (int h = 0; h < NumHosts; h++)
        if (w_win_vld[d] && (w_win_id[d] == HW'(h))) begin
          w_we    = host_we_i[h];
          w_addr  = host_addr_i[h*AddrWidth +: AddrWidth];
          w_wdata = host_wdata_i[h*DataWidth +: DataWidth];
          w_be    = host_be_i[h*BW +: BW];
        end
    end

    assign dev_we_o[d]                        = w_we;
    assign dev_addr_o[d*AddrWidth +: AddrWidth] = w_addr;
    assign dev_wdata_o[d*DataWidth +: DataWidth] = w_wdata;
    assign dev_be_o[d*BW +: BW]               = w_be;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_ptr <= '0;
      end else begin
        if (w_push[d]) begin
          r_wp  <= (r_wp == PW'(DevOutstanding - 1)) ? '0 : r_wp + 1'b1;
          r_ptr <= (w_win_id[d] == HW'(NumHosts - 1)) ? '0 : w_win_id[d] + 1'b1;
        end
        if (w_pop[d]) r_rp <= (r_rp == PW'(DevOutstanding - 1)) ? '0 : r_rp + 1'b1;
        case ({w_push[d], w_pop[d]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_push[d]) r_fifo[r_wp] <= w_win_id[d];
    end

    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
                                      !(dev_rvalid_i[d] && (r_cnt == '0)));
  end

endmodule

// File: tb/tb_soc_bus_xbar.sv
// tb/tb_soc_bus_xbar.sv - directed and randomized bench for soc_bus_xbar against a queue-based model
module tb_soc_bus_xbar;
  localparam int N = 3, M = 3, AW = 32, DW = 32, BW = 4, DEP = 2;
`ifdef SOC_BUS_XBAR_RSP_REG_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic [N-1:0] host_req, host_we;
  logic [N*AW-1:0] host_addr;
  logic [N*DW-1:0] host_wdata;
  logic [N*BW-1:0] host_be;
  logic [N-1:0] host_gnt, host_rvalid, host_err;
  logic [N*DW-1:0] host_rdata;
  logic [M-1:0] dev_req, dev_we;
  logic [M*AW-1:0] dev_addr;
  logic [M*DW-1:0] dev_wdata;
  logic [M*BW-1:0] dev_be;
  logic [M-1:0] dev_gnt, dev_rvalid, dev_err;
  logic [M*DW-1:0] dev_rdata;

  soc_bus_xbar #(.NumHosts(N), .NumDevices(M), .AddrWidth(AW), .DataWidth(DW), .DevOutstanding(DEP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_be_i(host_be),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata), .dev_be_o(dev_be),
    .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model state: who is waiting, per-device order of issued requests, RR start point.
  bit          pend [N];
  int          q [M][$];
  int          ptr [M];
  bit          err_due [N];
  bit          prv_v [N];
  bit          prv_e [N];
  logic [DW-1:0] prv_d [N];

  logic [N-1:0]    s_gnt, s_rv, s_err;
  logic [N*DW-1:0] s_rd;
  logic [M-1:0]    s_dreq;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address map: three 8 KiB windows starting at 0; everything else is unmapped.
  function automatic int region(input logic [31:0] a);
    if (a < 32'h2000) return 0;
    if (a < 32'h4000) return 1;
    if (a < 32'h6000) return 2;
    return M;
  endfunction

  task automatic model_reset();
    for (int h = 0; h < N; h++) begin
      pend[h] = 0; err_due[h] = 0; prv_v[h] = 0; prv_e[h] = 0; prv_d[h] = '0;
    end
    for (int d = 0; d < M; d++) begin
      q[d].delete(); ptr[d] = 0;
    end
    s_gnt = '0;
  endtask

  task automatic step();
    bit raw_v [N]; bit raw_e [N]; logic [DW-1:0] raw_d [N];
    bit vis_v [N]; bit vis_e [N]; logic [DW-1:0] vis_d [N];
    bit ep [N]; int tgt [N]; int win [M]; bit dreq [M]; bit egnt [N];
    logic [N-1:0] e_gnt, e_rv, e_err; logic [M-1:0] e_dreq;
    int hh;
    @(negedge clk_i);
    for (int h = 0; h < N; h++) begin
      raw_v[h] = err_due[h]; raw_e[h] = err_due[h]; raw_d[h] = '0;
    end
    for (int d = 0; d < M; d++)
      if (dev_rvalid[d] && q[d].size() > 0) begin
        hh = q[d][0];
        raw_v[hh] = 1; raw_e[hh] = dev_err[d]; raw_d[hh] = dev_rdata[d*DW +: DW];
      end
    for (int h = 0; h < N; h++) begin
      vis_v[h] = (RL == 1) ? prv_v[h] : raw_v[h];
      vis_e[h] = (RL == 1) ? prv_e[h] : raw_e[h];
      vis_d[h] = (RL == 1) ? prv_d[h] : raw_d[h];
      ep[h]    = pend[h] && !vis_v[h];
      tgt[h]   = region(host_addr[h*AW +: AW]);
    end
    e_gnt = '0;
    for (int d = 0; d < M; d++) begin
      win[d] = -1;
      for (int k = 0; k < N; k++) begin
        hh = (ptr[d] + k) % N;
        if (win[d] < 0 && host_req[hh] && !ep[hh] && tgt[hh] == d) win[d] = hh;
      end
      dreq[d]   = (win[d] >= 0) && (q[d].size() < DEP);
      e_dreq[d] = dreq[d];
      if (dreq[d] && dev_gnt[d]) e_gnt[win[d]] = 1'b1;
    end
    for (int h = 0; h < N; h++) begin
      egnt[h] = host_req[h] && !ep[h] && tgt[h] == M;
      if (egnt[h]) e_gnt[h] = 1'b1;
      e_rv[h] = vis_v[h]; e_err[h] = vis_v[h] && vis_e[h];
    end
    s_gnt = host_gnt; s_rv = host_rvalid; s_err = host_err; s_rd = host_rdata; s_dreq = dev_req;
    chk("host_gnt", host_gnt, e_gnt);
    chk("dev_req", dev_req, e_dreq);
    chk("host_rvalid", host_rvalid, e_rv);
    chk("host_err", host_err, e_err);
    for (int h = 0; h < N; h++)
      chk("host_rdata", host_rdata[h*DW +: DW], vis_v[h] ? vis_d[h] : '0);
    for (int d = 0; d < M; d++)
      if (dreq[d]) begin
        chk("dev_addr", dev_addr[d*AW +: AW], host_addr[win[d]*AW +: AW]);
        chk("dev_we", dev_we[d], host_we[win[d]]);
        chk("dev_wdata", dev_wdata[d*DW +: DW], host_wdata[win[d]*DW +: DW]);
        chk("dev_be", dev_be[d*BW +: BW], host_be[win[d]*BW +: BW]);
      end
    @(posedge clk_i);
    for (int d = 0; d < M; d++) begin
      if (dev_rvalid[d] && q[d].size() > 0) void'(q[d].pop_front());
      if (dreq[d] && dev_gnt[d]) begin
        q[d].push_back(win[d]);
        ptr[d] = (win[d] + 1) % N;
      end
    end
    for (int h = 0; h < N; h++) begin
      pend[h] = ep[h] || e_gnt[h];
      err_due[h] = egnt[h];
      prv_v[h] = raw_v[h]; prv_e[h] = raw_e[h]; prv_d[h] = raw_d[h];
    end
    #1;
  endtask

  task automatic set_host(input int h, input logic [31:0] a, input logic we);
    host_req[h] = 1'b1;
    host_we[h] = we;
    host_addr[h*AW +: AW] = a;
    host_wdata[h*DW +: DW] = $urandom;
    host_be[h*BW +: BW] = 4'($urandom_range(0, 15));
  endtask

  task automatic rand_req(input int h);
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 4);
    if (r < 3) a = r * 32'h2000 + $urandom_range(0, 8191);
    else if (r == 3) a = 32'h8000_0000 | $urandom;
    else a = 32'h6000 + $urandom_range(0, 255);
    set_host(h, a, 1'($urandom_range(0, 1)));
  endtask

  int seq_rv [$];
  int g2;

  initial begin
    rst_i = 1'b1;
    host_req = '0; host_we = '0; host_addr = '0; host_wdata = '0; host_be = '0;
    dev_gnt = '0; dev_rvalid = '0; dev_err = '0; dev_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", host_gnt, '0);
    chk("rst_rvalid", host_rvalid, '0);
    chk("rst_rdata", host_rdata, '0);
    chk("rst_err", host_err, '0);
    chk("rst_dev_req", dev_req, '0);
    chk("rst_dev_fields", {dev_we, dev_addr, dev_wdata, dev_be}, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Host0 read to dev0, response one cycle after grant.
    set_host(0, 32'h0000_0010, 1'b0);
    dev_gnt[0] = 1'b1;
    step();
    chk("t1_gnt", s_gnt, 3'b001);
    host_req = '0; dev_gnt = '0;
    dev_rvalid[0] = 1'b1; dev_rdata[0 +: DW] = 32'hA5A5_0001; dev_err[0] = 1'b0;
    step();
    dev_rvalid = '0;
    if (RL == 1) step();
    chk("t1_rvalid", s_rv, 3'b001);
    chk("t1_rdata", s_rd[0 +: DW], 32'hA5A5_0001);
    chk("t1_err", s_err, 3'b000);
    step();

    // Two hosts hammer dev1: grants alternate.
    set_host(0, 32'h0000_2040, 1'b1);
    set_host(1, 32'h0000_3FFC, 1'b0);
    dev_gnt[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dev_rvalid[1] = q[1].size() > 0;
      dev_rdata[DW +: DW] = $urandom;
      step();
      chk("t2_alt", s_gnt, (i % 2 == 0) ? 3'b001 : 3'b010);
    end
    host_req = '0; dev_gnt = '0;
    for (int i = 0; i < 4; i++) begin
      dev_rvalid[1] = q[1].size() > 0;
      step();
    end
    dev_rvalid = '0;

    // Unmapped address answered by the error responder.
    set_host(1, 32'h8000_0000, 1'b0);
    step();
    chk("t3_gnt", s_gnt, 3'b010);
    host_req = '0;
    step();
    if (RL == 1) step();
    chk("t3_rvalid", s_rv, 3'b010);
    chk("t3_err", s_err, 3'b010);
    chk("t3_rdata", s_rd, '0);
    step();

    // Three hosts on dev2 with a two-deep id FIFO and slow responses.
    set_host(0, 32'h0000_4000, 1'b0);
    set_host(1, 32'h0000_4004, 1'b0);
    set_host(2, 32'h0000_5FFC, 1'b1);
    dev_gnt[2] = 1'b1;
    g2 = -1;
    seq_rv.delete();
    for (int c = 0; c < 13; c++) begin
      dev_rvalid[2] = (c == 5 || c == 7 || c == 9) && q[2].size() > 0;
      dev_rdata[2*DW +: DW] = 32'h0000_0100 + c;
      step();
      if (c == 3) chk("t4_blocked", s_dreq[2], 1'b0);
      if (s_gnt[2]) g2 = c;
      for (int h = 0; h < N; h++) begin
        if (s_rv[h]) seq_rv.push_back(h);
        if (s_gnt[h]) host_req[h] = 1'b0;
      end
    end
    dev_rvalid = '0; dev_gnt = '0;
    chk("t4_third_after_pop", g2 > 5, 1'b1);
    chk("t4_rsp_count", seq_rv.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t4_rsp_order", (seq_rv.size() > i) ? seq_rv[i] : -1, i);

    // Reset with two responses in flight, then a late device response.
    set_host(0, 32'h0000_0100, 1'b0);
    set_host(1, 32'h0000_0200, 1'b0);
    dev_gnt[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      for (int h = 0; h < N; h++) if (s_gnt[h]) host_req[h] = 1'b0;
    end
    chk("t5_inflight", q[0].size(), 2);
    host_req = '0; dev_gnt = '0;
    rst_i = 1'b1;
    dev_rvalid[0] = 1'b1; dev_rdata[0 +: DW] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("t5_rvalid", host_rvalid, '0);
    chk("t5_rdata", host_rdata, '0);
    chk("t5_outs", {host_gnt, host_err, dev_req, dev_addr}, '0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("t5_rvalid_late", host_rvalid, '0);
    @(posedge clk_i); #1;
    dev_rvalid = '0;
    rst_i = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    set_host(0, 32'h0000_0008, 1'b0);
    dev_gnt[0] = 1'b1;
    step();
    chk("t5_regrant", s_gnt, 3'b001);
    host_req = '0; dev_gnt = '0;
    dev_rvalid[0] = 1'b1;
    step();
    dev_rvalid = '0;
    for (int i = 0; i < 2; i++) step();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int h = 0; h < N; h++) begin
        if (host_req[h] && s_gnt[h]) host_req[h] = 1'b0;
        if (!host_req[h] && $urandom_range(0, 2) == 0) rand_req(h);
      end
      for (int d = 0; d < M; d++) begin
        dev_gnt[d] = $urandom_range(0, 3) != 0;
        dev_rvalid[d] = (q[d].size() > 0) && ($urandom_range(0, 2) == 0);
        dev_rdata[d*DW +: DW] = $urandom;
        dev_err[d] = $urandom_range(0, 7) == 0;
      end
      step();
    end
    host_req = '0; dev_gnt = '0;
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < M; d++) dev_rvalid[d] = q[d].size() > 0;
      step();
    end
    dev_rvalid = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
